// File: rtl/koa_product_normalizer.sv
// koa_product_normalizer: normalizes and rounds a 2*SW-bit Karatsuba significand product to SW bits.
// Optional KOA_NORM_RMODE_EN adds rmode_i/sign_i for directed rounding; default is fixed RNE.
module koa_product_normalizer #(
    parameter int SW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2*SW-1:0] product_i,
`ifdef KOA_NORM_RMODE_EN
    input  logic [1:0]      rmode_i,
    input  logic            sign_i,
`endif
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [SW-1:0]   mant_o,
    output logic            norm_shift_o,
    output logic            round_ovf_o,
    output logic            inexact_o,
    output logic            zero_o,
    output logic            unnorm_o
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
    state_t state, state_nxt;
    logic [2*SW-1:0] p;
    logic [SW-1:0] m, m_nxt;
    logic g, s, shift, g_nxt, s_nxt, inc;
    logic [SW:0] sum;
    assign in_ready_o = (state == IDLE);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid_i ? NORM : IDLE;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = OUT;
            OUT:     state_nxt = out_ready_i ? IDLE : OUT;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        m_nxt = p[2*SW-1] ? p[2*SW-1:SW] : p[2*SW-2:SW-1];
        g_nxt = p[2*SW-1] ? p[SW-1] : p[SW-2];
        s_nxt = p[2*SW-1] ? |p[SW-2:0] : |p[SW-3:0];
    end
`ifdef KOA_NORM_RMODE_EN
    logic [1:0] rmode_r;
    logic sign_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            rmode_r <= '0;
            sign_r  <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            rmode_r <= rmode_i;
            sign_r  <= sign_i;
        end
    end
    // 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
    assign inc = rmode_r[1] ? (g | s) & (rmode_r[0] ? sign_r : ~sign_r)
               : rmode_r[0] ? 1'b0 : g & (s | m[0]);
`else
    assign inc = g & (s | m[0]);
`endif
    assign sum = {1'b0, m} + {{SW{1'b0}}, inc};
    always_ff @(posedge clk) begin
        if (rst) begin
            p            <= '0;
            m            <= '0;
            g            <= 1'b0;
            s            <= 1'b0;
            shift        <= 1'b0;
            out_valid_o  <= 1'b0;
            mant_o       <= '0;
            norm_shift_o <= 1'b0;
            round_ovf_o  <= 1'b0;
            inexact_o    <= 1'b0;
            zero_o       <= 1'b0;
            unnorm_o     <= 1'b0;
        end else begin
            if (in_valid_i && in_ready_o) p <= product_i;
            if (state == NORM) begin
                m     <= m_nxt;
                g     <= g_nxt;
                s     <= s_nxt;
                shift <= p[2*SW-1];
            end
            if (state == ROUND) begin
                mant_o       <= sum[SW] ? {1'b1, {(SW-1){1'b0}}} : sum[SW-1:0];
                round_ovf_o  <= sum[SW];
                norm_shift_o <= shift;
                inexact_o    <= g | s;
                zero_o       <= (p == '0);
                unnorm_o     <= (p[2*SW-1 -: 2] == 2'b00) && (p != '0);
                out_valid_o  <= 1'b1;
            end
            if (state == OUT && out_ready_i) out_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_koa_product_normalizer.sv
// tb_koa_product_normalizer: randomized self-checking bench against an arithmetic reference model.
module tb_koa_product_normalizer;
    localparam int SW = 24;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, sign = 1'b0;
    logic [1:0] rmode = 2'b00;
    logic [2*SW-1:0] product = '0;
    logic in_ready, out_valid, norm_shift, round_ovf, inexact, zero, unnorm;
    logic [SW-1:0] mant;
    int checks = 0, errors = 0;

    koa_product_normalizer #(.SW(SW)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .product_i(product),
`ifdef KOA_NORM_RMODE_EN
        .rmode_i(rmode), .sign_i(sign),
`endif
        .out_valid_o(out_valid), .out_ready_i(out_ready), .mant_o(mant),
        .norm_shift_o(norm_shift), .round_ovf_o(round_ovf), .inexact_o(inexact),
        .zero_o(zero), .unnorm_o(unnorm)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Reference: {mant, norm_shift, round_ovf, inexact, zero, unnorm}
    function automatic logic [SW+4:0] model(input logic [2*SW-1:0] pin, input logic [1:0] rm, input logic sg);
        longint unsigned pv, kept, rem, half;
        int sh;
        logic ns, ro, ix, up;
        pv = 64'(pin);
        ns = pv >= (64'd1 << (2*SW-1));
        sh = ns ? SW : SW-1;
        kept = pv >> sh;
        rem = pv & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh-1);
        ix = rem != 0;
        case (rm)
            2'b00: up = (rem > half) || (rem == half && kept[0]);
            2'b01: up = 1'b0;
            2'b10: up = ix && !sg;
            default: up = ix && sg;
        endcase
        kept = kept + 64'(up);
        ro = kept == (64'd1 << SW);
        if (ro) kept = 64'd1 << (SW-1);
        return {kept[SW-1:0], ns, ro, ix, pv == 0, (pv >> (2*SW-2)) == 0 && pv != 0};
    endfunction

    function automatic logic [SW+4:0] observed();
        return {mant, norm_shift, round_ovf, inexact, zero, unnorm};
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s: in_ready stuck low, got %b want 1", name, in_ready);
        end
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL %s latency: got %0d edges after accept, want 2", name, lat);
        end
    endtask

    task automatic do_txn(input logic [2*SW-1:0] prod, input logic [1:0] rm, input logic sg,
                          input bit rdy_always, input string name);
        logic [SW+4:0] exp_v;
        int lat;
        wait_ready(name);
        out_ready = rdy_always;
        in_valid = 1'b1; product = prod; rmode = rm; sign = sg;
        @(posedge clk); #1;
        in_valid = 1'b0; product = {16'($urandom), 32'($urandom)}; rmode = 2'($urandom); sign = 1'($urandom);
        exp_v = model(prod, rm, sg);
        wait_valid(name, lat);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL %s result: prod=%h got mant=%h flags(ns,ro,ix,z,un)=%b want mant=%h flags=%b",
                     name, prod, mant, observed()[4:0], exp_v[SW+4:5], exp_v[4:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s drain: got out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, {(SW+5){1'b0}}}) begin
            errors++;
            $display("FAIL reset: got out_valid=%b in_ready=%b mant=%h flags=%b want 0 1 0 0",
                     out_valid, in_ready, mant, observed()[4:0]);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        do_txn(48'h400000000000, 2'b00, 1'b0, 1'b0, "one_x_one");
        do_txn(48'h900000000000, 2'b00, 1'b0, 1'b0, "onehalf_sq");
        do_txn(48'h600000C00000, 2'b00, 1'b0, 1'b0, "tie_odd_rne");
        do_txn(48'h7FFFFFFFFFFF, 2'b00, 1'b0, 1'b0, "round_ovf");
        do_txn(48'hFFFFFE000001, 2'b00, 1'b0, 1'b0, "shift_noinc");
        do_txn(48'h000000000000, 2'b00, 1'b0, 1'b0, "zero");
        do_txn(48'h200000000001, 2'b00, 1'b0, 1'b0, "unnorm");
        do_txn(48'h400000400000, 2'b00, 1'b0, 1'b1, "tie_even_rne");
`ifdef KOA_NORM_RMODE_EN
        do_txn(48'h600000C00000, 2'b01, 1'b0, 1'b0, "tie_odd_rtz");
        do_txn(48'h400000000001, 2'b10, 1'b0, 1'b0, "rup_pos");
        do_txn(48'h400000000001, 2'b10, 1'b1, 1'b0, "rup_neg");
        do_txn(48'h400000000001, 2'b11, 1'b1, 1'b0, "rdn_neg");
        do_txn(48'h000000000000, 2'b10, 1'b0, 1'b0, "zero_rup");
`endif
    endtask

    task automatic test_random();
        logic [2*SW-1:0] r;
        logic [SW-1:0] a, b;
        logic [1:0] rm;
        for (int i = 0; i < 60; i++) begin
            a = SW'($urandom) | {1'b1, {(SW-1){1'b0}}};
            b = SW'($urandom) | {1'b1, {(SW-1){1'b0}}};
            case ($urandom_range(0, 3))
                0: r = a * b;
                1: r = {16'($urandom), 32'($urandom)};
                2: begin r = a * b; r[SW-2:0] = {1'b1, {(SW-2){1'b0}}}; r[2*SW-1] = 1'b0; r[2*SW-2] = 1'b1; end
                default: begin r = a * b; r[SW-1:0] = {1'b1, {(SW-1){1'b0}}}; r[2*SW-1] = 1'b1; end
            endcase
`ifdef KOA_NORM_RMODE_EN
            rm = 2'($urandom);
`else
            rm = 2'b00;
`endif
            do_txn(r, rm, 1'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [SW+4:0] held, exp_b;
        int lat;
        wait_ready("bp");
        in_valid = 1'b1; product = 48'h600000C00000; rmode = 2'b00; sign = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid("bp", lat);
        held = observed();
        in_valid = 1'b1; product = 48'h900000000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (observed() !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got out_valid=%b in_ready=%b mant=%h want 1 0 %h",
                         i, out_valid, in_ready, mant, held[SW+4:5]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: got in_ready=%b want 0", in_ready);
        end
        exp_b = model(48'h900000000000, 2'b00, 1'b0);
        wait_valid("bp_second", lat);
        checks++;
        if (observed() !== exp_b) begin
            errors++;
            $display("FAIL bp_second result: got mant=%h flags=%b want mant=%h flags=%b",
                     mant, observed()[4:0], exp_b[SW+4:5], exp_b[4:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        wait_ready("rst_mid");
        in_valid = 1'b1; product = 48'h7FFFFFFFFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, {(SW+5){1'b0}}}) begin
            errors++;
            $display("FAIL rst_mid: got out_valid=%b in_ready=%b mant=%h flags=%b want 0 1 0 0",
                     out_valid, in_ready, mant, observed()[4:0]);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_novalid: got %0d out_valid cycles want 0", seen);
        end
        do_txn(48'h400000000000, 2'b00, 1'b0, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
